// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT)
// with request/ack instruction and data memory ports and a 32x32 register file.
module mips_multicycle #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] SP_INIT = 32'h0000_0000,
  parameter logic [31:0] RA_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] FN_NOP     = 6'b000000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res;
  logic [31:0] r_rf [32];
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic        r_retire;
  logic        r_halted;

  // Instruction fields
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic        w_unused_shamt;

  assign w_op           = r_ir[31:26];
  assign w_rs           = r_ir[25:21];
  assign w_rt           = r_ir[20:16];
  assign w_rd           = r_ir[15:11];
  assign w_funct        = r_ir[5:0];
  assign w_imm          = r_ir[15:0];
  assign w_simm         = {{16{w_imm[15]}}, w_imm};
  assign w_unused_shamt = ^r_ir[10:6];

  // Decoded instruction class
  logic w_special, w_nop, w_jr, w_addu, w_subu;
  logic w_addiu, w_lui, w_beq, w_bne, w_lw, w_sw;
  logic w_legal, w_is_mem, w_is_wb;
  logic [4:0] w_dest;

  assign w_special = (w_op == OP_SPECIAL);
  assign w_nop     = w_special && (w_funct == FN_NOP);
  assign w_jr      = w_special && (w_funct == FN_JR);
  assign w_addu    = w_special && (w_funct == FN_ADDU);
  assign w_subu    = w_special && (w_funct == FN_SUBU);
  assign w_addiu   = (w_op == OP_ADDIU);
  assign w_lui     = (w_op == OP_LUI);
  assign w_beq     = (w_op == OP_BEQ);
  assign w_bne     = (w_op == OP_BNE);
  assign w_lw      = (w_op == OP_LW);
  assign w_sw      = (w_op == OP_SW);
  assign w_legal   = w_nop | w_jr | w_addu | w_subu | w_addiu | w_lui |
                     w_beq | w_bne | w_lw | w_sw;
  assign w_is_mem  = w_lw | w_sw;
  assign w_is_wb   = w_addu | w_subu | w_addiu | w_lui;
  assign w_dest    = (w_addu | w_subu) ? w_rd : w_rt;

  // Handshakes only count while the matching request is actually raised,
  // so a stray ack after reset cannot advance the machine.
  logic w_iack;
  logic w_dack;
  assign w_iack = imem_ack && r_imem_req;
  assign w_dack = dmem_ack && r_dmem_req;

  // Execute-stage arithmetic: ALU result or effective address, branch target
  logic [31:0] w_alu;
  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic        w_taken;
  logic        w_misaligned;

  assign w_pc4        = r_pc + 32'd4;
  assign w_br_tgt     = w_pc4 + (w_simm << 2);
  assign w_taken      = (w_beq && (r_a == r_b)) || (w_bne && (r_a != r_b));
  assign w_misaligned = (w_alu[1:0] != 2'b00);

  // ALU: ADDIU/LW/SW share the sign-extended add
  always_comb begin
    w_alu = r_a + w_simm;
    if (w_addu)     w_alu = r_a + r_b;
    else if (w_subu) w_alu = r_a - r_b;
    else if (w_lui)  w_alu = {w_imm, 16'h0000};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:  if (w_iack) w_state_next = DECODE;
      DECODE: w_state_next = w_legal ? EXEC : HALT;
      EXEC: begin
        if (w_is_mem)     w_state_next = w_misaligned ? HALT : MEM;
        else if (w_is_wb) w_state_next = WB;
        else              w_state_next = FETCH;
      end
      MEM:    if (w_dack) w_state_next = w_lw ? WB : FETCH;
      WB:     w_state_next = FETCH;
      HALT:   w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  // Control registers: PC, memory requests, retire/halt flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= PC_INIT;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_retire     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_imem_req <= (w_state_next == FETCH);
      r_retire   <= (w_state_next == FETCH) && (r_state != FETCH);
      r_halted   <= r_halted | (w_state_next == HALT);
      if (r_state == EXEC && w_state_next == FETCH) begin
        if (w_jr)         r_pc <= r_a;
        else if (w_taken) r_pc <= w_br_tgt;
        else              r_pc <= w_pc4;
      end else if ((r_state == WB || r_state == MEM) && w_state_next == FETCH) begin
        r_pc <= w_pc4;
      end
      if (r_state == EXEC && w_state_next == MEM) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= w_sw;
        r_dmem_addr  <= w_alu;
        r_dmem_wdata <= r_b;
      end else if (r_state == MEM && w_dack) begin
        r_dmem_req <= 1'b0;
        r_dmem_we  <= 1'b0;
      end
    end
  end

  // Datapath registers: instruction, operands, result / load data
  always_ff @(posedge clk) begin
    if (r_state == FETCH && w_iack) r_ir <= imem_rdata;
    if (r_state == DECODE) begin
      r_a <= (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
      r_b <= (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
    end
    if (r_state == EXEC)                  r_res <= w_alu;
    else if (r_state == MEM && w_dack && w_lw) r_res <= dmem_rdata;
  end

  // Register file: reset image with SP/RA preset, write-back discards r0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= (i == 29) ? SP_INIT : ((i == 31) ? RA_INIT : 32'd0);
    end else if (r_state == WB && w_dest != 5'd0) begin
      r_rf[w_dest] <= r_res;
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign retire     = r_retire;
  assign halted     = r_halted;

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed programs against mips_multicycle with a
// wait-state memory responder; register contents observed through stores.
`timescale 1ns/1ps
module tb_mips_multicycle;

  localparam logic [31:0] PC0 = 32'h0000_0100;
  localparam logic [31:0] SP0 = 32'h0000_2000;
  localparam logic [31:0] RA0 = 32'h0000_0ABC;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic        clk, reset;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  mips_multicycle #(.PC_INIT(PC0), .SP_INIT(SP0), .RA_INIT(RA0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];
  int          iwait, dwait, icnt, dcnt, dlen;
  bit          manual;
  logic [31:0] stall_addr;
  int          n_ret, n_dreq, n_unstable;
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  int          st_len  [$];
  logic [31:0] d_a0, d_w0;
  logic        d_we0;
  int          n_cmp, n_bad;
  logic [31:0] pa;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] addiu(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] i);
    return enc_i(6'b001001, rs, rt, i);
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rt, input logic [15:0] i);
    return enc_i(6'b001111, 5'd0, rt, i);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] base);
    return enc_i(6'b100011, base, rt, off);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] base);
    return enc_i(6'b101011, base, rt, off);
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] i);
    return enc_i(6'b000100, rs, rt, i);
  endfunction
  function automatic logic [31:0] bne(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] i);
    return enc_i(6'b000101, rs, rt, i);
  endfunction
  function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return enc_r(rs, rt, rd, 6'b100001);
  endfunction
  function automatic logic [31:0] subu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return enc_r(rs, rt, rd, 6'b100011);
  endfunction
  function automatic logic [31:0] jr(input logic [4:0] rs);
    return enc_r(rs, 5'd0, 5'd0, 6'b001000);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = ILL;
      dmem[i] = 32'd0;
    end
    pa = PC0;
  endtask

  task automatic emit(input logic [31:0] w);
    imem[pa[11:2]] = w;
    pa = pa + 32'd4;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[a[11:2]] = w;
  endtask

  task automatic clear_log();
    n_ret = 0; n_dreq = 0; n_unstable = 0;
    st_addr.delete(); st_data.delete(); st_len.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_stores(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && st_addr.size() < n; i++) @(negedge clk);
    chk(tag, st_addr.size(), n);
  endtask

  // Memory responder: programmable wait states, store log, stability watch
  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    icnt = 0; dcnt = 0; dlen = 0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (imem_req && !imem_ack) begin
          if (imem_addr != stall_addr) begin
            if (icnt >= iwait) begin
              imem_ack = 1'b1; imem_rdata = imem[imem_addr[11:2]]; icnt = 0;
            end else icnt++;
          end
        end else begin
          imem_ack = 1'b0; icnt = 0;
        end
      end
      if (dmem_req && !dmem_ack) begin
        if (dlen == 0) begin
          d_a0 = dmem_addr; d_w0 = dmem_wdata; d_we0 = dmem_we;
        end else if (dmem_addr != d_a0 || dmem_wdata != d_w0 || dmem_we != d_we0) n_unstable++;
        dlen++;
        if (dcnt >= dwait) begin
          dmem_ack = 1'b1; dcnt = 0;
          if (dmem_we) begin
            dmem[dmem_addr[11:2]] = dmem_wdata;
            st_addr.push_back(dmem_addr); st_data.push_back(dmem_wdata); st_len.push_back(dlen);
          end else dmem_rdata = dmem[dmem_addr[11:2]];
        end else dcnt++;
      end else begin
        dmem_ack = 1'b0; dcnt = 0; dlen = 0;
      end
      if (retire)   n_ret++;
      if (dmem_req) n_dreq++;
    end
  end

  initial begin
    logic [15:0] mask;
    logic [31:0] pc8;
    logic        req0;
    int          gap, found, cyc;
    logic [31:0] pcs [$];
    int          cq  [$];
    logic [31:0] exp_pc [8];
    logic [31:0] exp_st [7];

    n_cmp = 0; n_bad = 0; reset = 1'b1; manual = 1'b0;
    iwait = 0; dwait = 0; stall_addr = 32'hFFFF_FFFF;
    clear_log();

    // Test 1: reset state, ADDIU/ADDU/SW timing from PC_INIT
    clear_mem();
    emit(addiu(1, 0, 16'd5)); emit(addu(2, 1, 1)); emit(sw(2, 16'd0, 29));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);   chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);     chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0); chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);       chk("rst_pc", imem_addr, PC0);
    reset = 1'b0; clear_log();
    mask = '0; pc8 = '0; req0 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      mask[c] = retire;
      if (c == 0) req0 = imem_req;
      if (c == 8) pc8 = imem_addr;
    end
    chk("req_after_reset", req0, 1);
    chk("retire_mask", mask, 16'h1110);
    chk("pc_at_8", pc8, 32'h108);
    wait_stores("t1_store_cnt", 1, 40);
    chk("t1_addr", st_addr[0], 32'h2000);
    chk("t1_r2", st_data[0], 32'd10);

    // Test 2: SW with 3 wait states, LW back, re-store
    clear_mem(); dwait = 3;
    emit(addiu(1, 0, 16'h1234)); emit(sw(1, 16'd4, 29));
    emit(lw(5, 16'd4, 29));      emit(sw(5, 16'd8, 29));
    do_reset();
    wait_stores("t2_store_cnt", 2, 200);
    chk("t2_sw_addr", st_addr[0], 32'h2004);
    chk("t2_sw_data", st_data[0], 32'h1234);
    chk("t2_we_cycles", st_len[0], 4);
    chk("t2_lw_store_addr", st_addr[1], 32'h2008);
    chk("t2_lw_data", st_data[1], 32'h1234);
    chk("t2_stable", n_unstable, 0);
    dwait = 0;

    // Test 3: BEQ self-loop at 0x40 via JR
    clear_mem();
    put(32'h100, addiu(4, 0, 16'h40)); put(32'h104, jr(4));
    put(32'h40, beq(0, 0, 16'hFFFF));
    do_reset();
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (retire && imem_addr == 32'h40) begin found = 1; break; end
    end
    chk("t3_reach_40", found, 1);
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!retire && gap < 10);
      chk("t3_beq_gap", gap, 3);
      chk("t3_beq_pc", imem_addr, 32'h40);
    end

    // Test 4: BNE not-taken/taken, SW, JR to itself
    clear_mem();
    put(32'h100, addiu(4, 0, 16'h40)); put(32'h104, jr(4));
    put(32'h40, bne(0, 0, 16'd5));     put(32'h44, bne(4, 0, 16'd2));
    put(32'h50, sw(4, 16'd0, 29));     put(32'h54, addiu(6, 0, 16'h58));
    put(32'h58, jr(6));
    exp_pc = '{32'h104, 32'h40, 32'h44, 32'h50, 32'h54, 32'h58, 32'h58, 32'h58};
    do_reset();
    pcs.delete(); cq.delete(); cyc = 0;
    for (int i = 0; i < 150 && pcs.size() < 8; i++) begin
      @(negedge clk); cyc++;
      if (retire) begin pcs.push_back(imem_addr); cq.push_back(cyc); end
    end
    chk("t4_retire_cnt", pcs.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_pc%0d", i), pcs[i], exp_pc[i]);
    chk("t4_jr_gap_a", cq[6] - cq[5], 3);
    chk("t4_jr_gap_b", cq[7] - cq[6], 3);
    chk("t4_sw_data", st_data[0], 32'h40);

    // Test 5: illegal opcode, illegal funct, misaligned LW
    clear_mem();
    do_reset();
    repeat (20) @(negedge clk);
    chk("t5_ill_halted", halted, 1); chk("t5_ill_retire", n_ret, 0);
    chk("t5_ill_dreq", n_dreq, 0);   chk("t5_ill_pc", imem_addr, PC0);
    chk("t5_ill_ireq", imem_req, 0);
    put(PC0, enc_r(1, 2, 3, 6'h3F));
    do_reset();
    repeat (20) @(negedge clk);
    chk("t5_fn_halted", halted, 1); chk("t5_fn_retire", n_ret, 0);
    clear_mem();
    emit(addiu(6, 0, 16'h1002)); emit(lw(7, 16'd0, 6));
    do_reset();
    repeat (30) @(negedge clk);
    chk("t5_mis_halted", halted, 1); chk("t5_mis_retire", n_ret, 1);
    chk("t5_mis_dreq", n_dreq, 0);   chk("t5_mis_pc", imem_addr, 32'h104);

    // Test 6: r0 discard, wraps, LUI, SUBU, reset values of r29/r31
    clear_mem();
    emit(addiu(0, 0, 16'd7));     emit(addiu(3, 0, 16'hFFFF)); emit(addiu(3, 3, 16'd1));
    emit(lui(8, 16'hABCD));       emit(addiu(8, 8, 16'h1234)); emit(subu(9, 0, 8));
    emit(addiu(10, 0, 16'hFFFF)); emit(addu(11, 10, 10));
    emit(sw(0, 16'd0, 29));  emit(sw(3, 16'd4, 29));  emit(sw(8, 16'd8, 29));
    emit(sw(9, 16'd12, 29)); emit(sw(31, 16'd16, 29)); emit(sw(29, 16'd20, 29));
    emit(sw(11, 16'd24, 29));
    exp_st = '{32'd0, 32'd0, 32'hABCD_1234, 32'h5432_EDCC, RA0, SP0, 32'hFFFF_FFFE};
    do_reset();
    chk("t6_halt_cleared", halted, 0);
    wait_stores("t6_store_cnt", 7, 300);
    for (int i = 0; i < 7; i++) chk($sformatf("t6_st%0d", i), st_data[i], exp_st[i]);

    // Test 7: reset during a stalled fetch, late ack ignored
    clear_mem();
    emit(addiu(29, 0, 16'h300)); emit(addiu(31, 0, 16'h77));
    stall_addr = 32'h108;
    do_reset();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h108) begin found = 1; break; end
    end
    chk("t7_stalled", found, 1);
    repeat (3) @(negedge clk);
    chk("t7_req_held", imem_req, 1);
    put(32'h100, sw(31, 16'd0, 29)); put(32'h104, sw(29, 16'd4, 29));
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t7_req_drop", imem_req, 0);
    chk("t7_pc_init", imem_addr, PC0);
    manual = 1'b1; imem_ack = 1'b1; imem_rdata = ILL;
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0; manual = 1'b0; stall_addr = 32'hFFFF_FFFF;
    clear_log();
    wait_stores("t7_store_cnt", 2, 60);
    chk("t7_ra_addr", st_addr[0], SP0);
    chk("t7_ra_data", st_data[0], RA0);
    chk("t7_sp_data", st_data[1], SP0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
